zigzag_pingpong: RTL and testbench

Double-buffered 8x8 coefficient reorder stage between the quantiser and the entropy coder. It accepts one 8-coefficient row per handshake and emits the block as eight 8-coefficient beats, in either JPEG zigzag order or raster order. Two banks let one block be written while the other drains, so throughput is sustained at one beat per cycle. Both sides use valid/ready.

---
 rtl/zigzag_pkg.sv | 29 ++
 rtl/zigzag_bank.sv | 54 +++++
 rtl/zigzag_pingpong.sv | 108 ++++++++++
 tb/tb_zigzag_pingpong.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// Shared constants, mode encoding and scan-order lookup for zigzag_pingpong.
// Optional per-block nonzero statistics are enabled with ZIGZAG_LAST_NZ_EN.
package zigzag_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned LANES = 8;

    typedef enum logic {
        ZZ_MODE_ZIGZAG = 1'b0,
        ZZ_MODE_RASTER = 1'b1
    } zz_mode_e;

    // Scan position -> raster index (8*row + col) of the JPEG zigzag scan.
    localparam logic [5:0] ZZ_ORDER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_index(input zz_mode_e mode, input logic [5:0] pos);
        return (mode == ZZ_MODE_RASTER) ? pos : ZZ_ORDER[pos];
    endfunction

endpackage

// File: rtl/zigzag_bank.sv
// One 8x8 coefficient bank: row storage, block mode bit and beat reorder mux.
// With ZIGZAG_LAST_NZ_EN it also reports the last nonzero scan position.
module zigzag_bank
    import zigzag_pkg::*;
#(
    parameter int BW = 10
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [2:0]      i_row,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_mode,
    input  logic [2:0]      i_beat,
    output logic [8*BW-1:0] o_data
`ifdef ZIGZAG_LAST_NZ_EN
    ,
    output logic [5:0]      o_last_nz,
    output logic            o_all_zero
`endif
);

    logic [BW-1:0] coef_q [64];
    zz_mode_e      mode_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned c = 0; c < LANES; c++)
                coef_q[{i_row, 3'(c)}] <= i_data[(LANES-c)*BW-1 -: BW];
            if (i_row == '0)
                mode_q <= zz_mode_e'(i_mode);
        end
    end

    always_comb begin
        o_data = '0;
        for (int unsigned j = 0; j < LANES; j++)
            o_data[(LANES-j)*BW-1 -: BW] = coef_q[zz_index(mode_q, {i_beat, 3'(j)})];
    end

`ifdef ZIGZAG_LAST_NZ_EN
    // Later positions overwrite earlier ones, leaving the highest nonzero position.
    always_comb begin
        o_last_nz  = '0;
        o_all_zero = 1'b1;
        for (int unsigned p = 0; p < ROWS*LANES; p++) begin
            if (coef_q[zz_index(mode_q, 6'(p))] != '0) begin
                o_last_nz  = 6'(p);
                o_all_zero = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/zigzag_pingpong.sv
// Double-buffered 8x8 coefficient reorder stage (zigzag or raster output order).
// Define ZIGZAG_LAST_NZ_EN to add the o_last_nz / o_all_zero block statistics.
module zigzag_pingpong
    import zigzag_pkg::*;
#(
    parameter int BW = 10
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_mode,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [8*BW-1:0] o_data,
    output logic            o_first,
    output logic            o_last
`ifdef ZIGZAG_LAST_NZ_EN
    ,
    output logic [5:0]      o_last_nz,
    output logic            o_all_zero
`endif
);

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic [2:0] rd_beat_q, rd_beat_d;
    logic [1:0] full_q,    full_d;
    logic       wr_fire, rd_fire;

    logic [8*BW-1:0] bank_data [2];
`ifdef ZIGZAG_LAST_NZ_EN
    logic [5:0]      bank_lnz  [2];
    logic            bank_az   [2];
`endif

    assign o_ready = !full_q[wr_bank_q];
    assign o_valid = full_q[rd_bank_q];
    assign wr_fire = i_valid && o_ready;
    assign rd_fire = o_valid && i_ready;

    // Write and read never target the same bank: one needs it empty, the other full.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_beat_d = rd_beat_q;
        full_d    = full_q;
        if (wr_fire) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'(ROWS-1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_fire) begin
            rd_beat_d = rd_beat_q + 3'd1;
            if (rd_beat_q == 3'(ROWS-1)) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_Reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_beat_q <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_beat_q <= rd_beat_d;
            full_q    <= full_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        zigzag_bank #(.BW(BW)) u_bank (
            .i_clk      (i_clk),
            .i_we       (wr_fire && (wr_bank_q == 1'(b))),
            .i_row      (wr_row_q),
            .i_data     (i_data),
            .i_mode     (i_mode),
            .i_beat     (rd_beat_q),
            .o_data     (bank_data[b])
`ifdef ZIGZAG_LAST_NZ_EN
            ,
            .o_last_nz  (bank_lnz[b]),
            .o_all_zero (bank_az[b])
`endif
        );
    end

    assign o_data  = o_valid ? bank_data[rd_bank_q] : '0;
    assign o_first = o_valid && (rd_beat_q == '0);
    assign o_last  = o_valid && (rd_beat_q == 3'(ROWS-1));
`ifdef ZIGZAG_LAST_NZ_EN
    assign o_last_nz  = o_valid ? bank_lnz[rd_bank_q] : '0;
    assign o_all_zero = o_valid && bank_az[rd_bank_q];
`endif

endmodule

// File: tb/tb_zigzag_pingpong.sv
// Self-checking bench for zigzag_pingpong: block-queue model plus directed vectors.
// Build with ZIGZAG_LAST_NZ_EN defined to exercise the nonzero statistics too.
`timescale 1ns/1ps
module tb_zigzag_pingpong;

    localparam int BW = 10;

    logic            i_clk = 1'b0;
    logic            i_Reset = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [8*BW-1:0] i_data = '0;
    logic            i_mode = 1'b0;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic [8*BW-1:0] o_data;
    logic            o_first;
    logic            o_last;
`ifdef ZIGZAG_LAST_NZ_EN
    logic [5:0]      o_last_nz;
    logic            o_all_zero;
`endif

    always #5 i_clk = ~i_clk;

    zigzag_pingpong #(.BW(BW)) dut (
        .i_clk      (i_clk),
        .i_Reset    (i_Reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_mode     (i_mode),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_first    (o_first),
        .o_last     (o_last)
`ifdef ZIGZAG_LAST_NZ_EN
        ,
        .o_last_nz  (o_last_nz),
        .o_all_zero (o_all_zero)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: completed blocks waiting to drain (64 raster coefficients each) plus a partial block.
    int zz [64];
    int blk [64];
    int q_coef [$];
    bit q_mode [$];
    int part [64];
    int part_row = 0;
    bit part_mode = 1'b0;
    int beat = 0;
    int cyc = 0;
    int rows_acc = 0;

    logic [8*BW-1:0] cap_data [64];
    bit              cap_first [64];
    bit              cap_last [64];
    int              cap_lnz [64];
    bit              cap_az [64];
    int              cap_n = 0;

    bit push_mon = 1'b0, stream_mon = 1'b0, bp_done = 1'b0;
    int drops = 0, vbeats = 0, first_row_cyc = -1, first_val_cyc = -1, last_val_cyc = -1;

    task automatic chk(input string name, input logic [8*BW-1:0] act, input logic [8*BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at cyc %0d", name, cyc);
    endtask

    function automatic logic [8*BW-1:0] pk(input int v[8]);
        logic [8*BW-1:0] r;
        r = '0;
        for (int c = 0; c < 8; c++) r[(8-c)*BW-1 -: BW] = BW'(v[c]);
        return r;
    endfunction

    // Zigzag order built by walking anti-diagonals, alternating direction.
    task automatic build_zz();
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            for (int t = 0; t < 8; t++) begin
                int r, c;
                r = (s % 2 == 0) ? ((s < 8 ? s : 7) - t) : ((s < 8 ? 0 : s - 7) + t);
                c = s - r;
                if (r >= 0 && r < 8 && c >= 0 && c < 8) begin
                    zz[n] = 8 * r + c;
                    n++;
                end
            end
        end
    endtask

    initial begin : compare
        logic [8*BW-1:0] exp_data;
        logic [BW-1:0]   v;
        bit              exp_valid, exp_ready, exp_az;
        int              exp_lnz, idx;
        build_zz();
        forever begin
            @(negedge i_clk);
            cyc++;
            exp_valid = q_mode.size() > 0;
            exp_ready = q_mode.size() < 2;
            exp_data  = '0;
            exp_lnz   = 0;
            exp_az    = 1'b0;
            if (exp_valid) begin
                for (int j = 0; j < 8; j++) begin
                    idx = q_mode[0] ? 8 * beat + j : zz[8 * beat + j];
                    v = BW'(q_coef[idx]);
                    exp_data[(8-j)*BW-1 -: BW] = v;
                end
                exp_az = 1'b1;
                for (int p = 0; p < 64; p++) begin
                    idx = q_mode[0] ? p : zz[p];
                    if (BW'(q_coef[idx]) != '0) begin
                        exp_lnz = p;
                        exp_az  = 1'b0;
                    end
                end
            end
            chk("o_ready", 80'(o_ready), 80'(exp_ready));
            chk("o_valid", 80'(o_valid), 80'(exp_valid));
            chk("o_data",  o_data, exp_data);
            chk("o_first", 80'(o_first), 80'(exp_valid && beat == 0));
            chk("o_last",  80'(o_last),  80'(exp_valid && beat == 7));
`ifdef ZIGZAG_LAST_NZ_EN
            chk("o_last_nz",  80'(o_last_nz),  80'(exp_lnz));
            chk("o_all_zero", 80'(o_all_zero), 80'(exp_az));
`endif
            if (push_mon && !o_ready) drops++;
            if (stream_mon && o_valid) begin
                vbeats++;
                if (first_val_cyc < 0) first_val_cyc = cyc;
                last_val_cyc = cyc;
            end
            if (stream_mon && i_valid && o_ready && first_row_cyc < 0) first_row_cyc = cyc;

            if (!i_Reset) begin
                q_coef.delete();
                q_mode.delete();
                part_row = 0;
                beat = 0;
            end else begin
                if (exp_valid && i_ready) begin
                    if (cap_n < 64) begin
                        cap_data[cap_n]  = o_data;
                        cap_first[cap_n] = o_first;
                        cap_last[cap_n]  = o_last;
`ifdef ZIGZAG_LAST_NZ_EN
                        cap_lnz[cap_n]   = int'(o_last_nz);
                        cap_az[cap_n]    = o_all_zero;
`endif
                        cap_n++;
                    end
                    if (beat == 7) begin
                        repeat (64) void'(q_coef.pop_front());
                        void'(q_mode.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                if (i_valid && exp_ready) begin
                    if (part_row == 0) part_mode = i_mode;
                    for (int c = 0; c < 8; c++)
                        part[8 * part_row + c] = int'($signed(i_data[(8-c)*BW-1 -: BW]));
                    part_row++;
                    rows_acc++;
                    if (part_row == 8) begin
                        for (int i = 0; i < 64; i++) q_coef.push_back(part[i]);
                        q_mode.push_back(part_mode);
                        part_row = 0;
                    end
                end
            end
        end
    end

    task automatic push_row(input int r, input logic m);
        bit hs;
        int unsigned t;
        hs = 1'b0;
        t = 0;
        for (int c = 0; c < 8; c++) i_data[(8-c)*BW-1 -: BW] = BW'(blk[8 * r + c]);
        i_mode  = m;
        i_valid = 1'b1;
        while (!hs && t < 300) begin
            @(negedge i_clk);
            hs = o_ready;
            @(posedge i_clk);
            #1;
            t++;
        end
        i_valid = 1'b0;
        if (!hs) timeout_fail("push_row");
    endtask

    task automatic push_block(input logic mode, input int flip_at);
        for (int r = 0; r < 8; r++) push_row(r, (r >= flip_at) ? ~mode : mode);
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        while (q_mode.size() != 0 && t < 300) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        if (t >= 300) timeout_fail("drain");
        @(posedge i_clk);
        #1;
    endtask

    initial begin : main
        int v [8];
        int n;
        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ready", 80'(o_ready), 80'(1));
        chk("rst_valid", 80'(o_valid), 80'(0));
        chk("rst_data",  o_data, '0);
        chk("rst_first", 80'(o_first), 80'(0));
        chk("rst_last",  80'(o_last), 80'(0));
        @(posedge i_clk);
        #1;
        i_Reset = 1'b1;

        // Zigzag block, coefficient (r,c) = 8r+c
        for (int i = 0; i < 64; i++) blk[i] = i;
        i_ready = 1'b1;
        cap_n = 0;
        push_block(1'b0, 8);
        drain();
        chk("zz_count", 80'(cap_n), 80'(8));
        v = '{0, 1, 8, 16, 9, 2, 3, 10};     chk("zz_beat0", cap_data[0], pk(v));
        v = '{17, 24, 32, 25, 18, 11, 4, 5};  chk("zz_beat1", cap_data[1], pk(v));
        v = '{58, 59, 52, 45, 38, 31, 39, 46}; chk("zz_beat6", cap_data[6], pk(v));
        v = '{53, 60, 61, 54, 47, 55, 62, 63}; chk("zz_beat7", cap_data[7], pk(v));
        chk("zz_first0", 80'(cap_first[0]), 80'(1));
        chk("zz_first3", 80'(cap_first[3]), 80'(0));
        chk("zz_last7",  80'(cap_last[7]),  80'(1));
        chk("zz_last6",  80'(cap_last[6]),  80'(0));

        // Raster block with i_mode flipped at row 3, then a zigzag block
        cap_n = 0;
        push_block(1'b1, 3);
        push_block(1'b0, 8);
        drain();
        v = '{16, 17, 18, 19, 20, 21, 22, 23}; chk("ras_beat2", cap_data[2], pk(v));
        v = '{56, 57, 58, 59, 60, 61, 62, 63}; chk("ras_beat7", cap_data[7], pk(v));
        v = '{0, 1, 8, 16, 9, 2, 3, 10};       chk("next_zz_beat0", cap_data[8], pk(v));

        // Streaming: 4 back-to-back blocks of signed random data
        push_mon = 1'b1;
        stream_mon = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 1023)) - 512;
            push_block(b[0], 8);
        end
        push_mon = 1'b0;
        drain();
        stream_mon = 1'b0;
        chk("stream_drops",   80'(drops), 80'(0));
        chk("stream_beats",   80'(vbeats), 80'(32));
        chk("stream_contig",  80'(last_val_cyc - first_val_cyc + 1), 80'(32));
        // Beat 0 lands in the ninth cycle counting the first row's cycle as the first.
        chk("stream_latency", 80'(first_val_cyc - first_row_cyc), 80'(8));

        // Back-pressure: three blocks offered with i_ready low
        i_ready = 1'b0;
        rows_acc = 0;
        bp_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 64; i++) blk[i] = 64 * b + i - 100;
                    push_block(1'b0, 8);
                end
                bp_done = 1'b1;
            end
        join_none
        n = 0;
        while (rows_acc < 16 && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("bp_rows",  80'(rows_acc), 80'(16));
        chk("bp_ready", 80'(o_ready), 80'(0));
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_ready && n < 50);
        chk("bp_release", 80'(n), 80'(9));
        n = 0;
        while (!bp_done && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!bp_done) timeout_fail("bp_done");
        drain();

        // Reset after 5 rows, then a fresh block
        for (int i = 0; i < 64; i++) blk[i] = 400 + i;
        for (int r = 0; r < 5; r++) push_row(r, 1'b0);
        i_Reset = 1'b0;
        @(posedge i_clk);
        #1;
        i_Reset = 1'b1;
        for (int i = 0; i < 64; i++) blk[i] = 100 + i;
        cap_n = 0;
        push_block(1'b0, 8);
        drain();
        chk("rst_count", 80'(cap_n), 80'(8));
        v = '{100, 101, 108, 116, 109, 102, 103, 110}; chk("rst_beat0", cap_data[0], pk(v));

`ifdef ZIGZAG_LAST_NZ_EN
        // Only raster index 9 nonzero (zigzag position 4), then an all-zero block
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[9] = -3;
        cap_n = 0;
        push_block(1'b0, 8);
        blk[9] = 0;
        push_block(1'b0, 8);
        drain();
        for (int k = 0; k < 8; k++) begin
            chk("lnz_single", 80'(cap_lnz[k]), 80'(4));
            chk("az_single",  80'(cap_az[k]),  80'(0));
            chk("lnz_zero",   80'(cap_lnz[8 + k]), 80'(0));
            chk("az_zero",    80'(cap_az[8 + k]),  80'(1));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
